gpdout_bank: RTL

// Multi-channel general-purpose output bank; successor to the single 32-bit gpdout register.

---
 rtl/gpdout_bank.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/gpdout_bank.sv
// gpdout_bank: multi-channel general-purpose output bank with
// atomic SET/CLR, timed one-shot PULSE masks and 1-cycle readback.
//
// Ports:
//   clk     in  1              rising-edge clock
//   reset   in  1              asynchronous active-high reset
//   en      in  1              bus select
//   wen     in  NB             per-byte-lane write enables (bus order)
//   ren     in  1              read request
//   addr    in  CW+2           [1:0] reg (DATA/SET/CLR/PULSE), [CW+1:2] channel
//   din     in  DATA_W         write data, bus order
//   rdata   out DATA_W         read data, bus order
//   rvalid  out 1              one-cycle read strobe
//   pins    out NUM_CH*DATA_W  channel c on [c*DATA_W +: DATA_W], pin order
//   busy    out NUM_CH         channel pulse active

module gpdout_bank #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 32,
    parameter int SWAP_BYTES = 1,
    parameter int PULSE_LEN  = 16,
    parameter int PULSE_W    = 16,
    localparam int NB        = DATA_W / 8,
    localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [NB-1:0]            wen,
    input  logic                     ren,
    input  logic [CW+1:0]            addr,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rvalid,
    output logic [NUM_CH*DATA_W-1:0] pins,
    output logic [NUM_CH-1:0]        busy
);

    localparam logic [1:0] REG_DATA  = 2'd0;
    localparam logic [1:0] REG_SET   = 2'd1;
    localparam logic [1:0] REG_CLR   = 2'd2;
    localparam logic [1:0] REG_PULSE = 2'd3;

    localparam logic [PULSE_W-1:0] CNT_LOAD = PULSE_W'(PULSE_LEN);
    localparam logic [PULSE_W-1:0] CNT_ONE  = PULSE_W'(1);

    // Bus lane -> pin byte index; the map is its own inverse,
    // so the same function serves the readback direction.
    function automatic int lane_map(input int i);
        return (SWAP_BYTES != 0) ? (NB - 1 - i) : i;
    endfunction

    logic [DATA_W-1:0]  base_q [NUM_CH];
    logic [DATA_W-1:0]  base_d [NUM_CH];
    logic [DATA_W-1:0]  mask_q [NUM_CH];
    logic [DATA_W-1:0]  mask_d [NUM_CH];
    logic [PULSE_W-1:0] cnt_q  [NUM_CH];
    logic [PULSE_W-1:0] cnt_d  [NUM_CH];

    logic [DATA_W-1:0]  rdata_q;
    logic [DATA_W-1:0]  rdata_d;
    logic               rvalid_q;
    logic               rvalid_d;

    logic [CW-1:0]      ch;
    logic [1:0]         rsel;
    logic               wr_en;
    logic               rd_en;
    logic [DATA_W-1:0]  rd_word;

    assign ch    = addr[CW+1:2];
    assign rsel  = addr[1:0];
    assign wr_en = en && (|wen);
    assign rd_en = en && ren;

    // Channel state: pulse countdown plus bus writes.
    // Channel indices >= NUM_CH never match the loop, so such
    // writes fall through with no state change.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            base_d[c] = base_q[c];
            mask_d[c] = mask_q[c];
            cnt_d[c]  = cnt_q[c];

            if (cnt_q[c] != '0) begin
                cnt_d[c] = cnt_q[c] - CNT_ONE;
                if (cnt_q[c] == CNT_ONE) begin
                    mask_d[c] = '0;
                end
            end

            if (wr_en && (ch == CW'(c))) begin
                case (rsel)
                    REG_DATA: begin
                        for (int i = 0; i < NB; i++) begin
                            if (wen[i]) begin
                                base_d[c][8*lane_map(i) +: 8] =
                                    din[8*i +: 8];
                            end
                        end
                    end
                    REG_SET: begin
                        for (int i = 0; i < NB; i++) begin
                            if (wen[i]) begin
                                base_d[c][8*lane_map(i) +: 8] =
                                    base_q[c][8*lane_map(i) +: 8]
                                    | din[8*i +: 8];
                            end
                        end
                    end
                    REG_CLR: begin
                        for (int i = 0; i < NB; i++) begin
                            if (wen[i]) begin
                                base_d[c][8*lane_map(i) +: 8] =
                                    base_q[c][8*lane_map(i) +: 8]
                                    & ~din[8*i +: 8];
                            end
                        end
                    end
                    REG_PULSE: begin
                        // Whole mask is replaced: unwritten lanes clear.
                        // A reload here also overrides the countdown,
                        // giving a gap-free retrigger.
                        mask_d[c] = '0;
                        for (int i = 0; i < NB; i++) begin
                            if (wen[i]) begin
                                mask_d[c][8*lane_map(i) +: 8] =
                                    din[8*i +: 8];
                            end
                        end
                        cnt_d[c] = CNT_LOAD;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Readback samples the registered state, so a same-cycle
    // write to the same channel returns the pre-write value.
    always_comb begin
        rd_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch == CW'(c)) begin
                rd_word = (rsel == REG_PULSE) ? mask_q[c] : base_q[c];
            end
        end
    end

    always_comb begin
        rvalid_d = rd_en;
        rdata_d  = rdata_q;
        if (rd_en) begin
            for (int i = 0; i < NB; i++) begin
                rdata_d[8*i +: 8] = rd_word[8*lane_map(i) +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                base_q[c] <= '0;
                mask_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                base_q[c] <= base_d[c];
                mask_q[c] <= mask_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Outputs come straight from flops; no combinational bus path.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_out
        assign pins[c*DATA_W +: DATA_W] = base_q[c] ^ mask_q[c];
        assign busy[c]                  = (cnt_q[c] != '0);
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule
